smm_scheduler: RTL and testbench



---
 rtl/kalman_pkg.sv | 14 +
 rtl/smm_scheduler_if.sv | 30 +++
 rtl/rr_pick.sv | 33 +++
 rtl/smm_scheduler.sv | 107 ++++++++++
 tb/tb_smm_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kalman_pkg.sv
// Shared Kalman datapath definitions: matrix bus width, multiplier latency, scheduler states.
package kalman_pkg;

    localparam int SMM_N       = 32;
    localparam int SMM_LATENCY = 18;
    localparam int MAT_W       = 16 * SMM_N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } smm_state_e;

endpackage

// File: rtl/smm_scheduler_if.sv
// Requester and multiplier bundle for the shared 4x4 multiplier scheduler.
interface smm_scheduler_if #(
    parameter int N    = 32,
    parameter int NREQ = 4
);
    localparam int MW = 16 * N;

    logic [NREQ-1:0]    req;
    logic [NREQ*MW-1:0] req_a;
    logic [NREQ*MW-1:0] req_b;
    logic [NREQ-1:0]    grant;
    logic               done;
    logic [MW-1:0]      result;
    logic               busy;
    logic [MW-1:0]      mm_a;
    logic [MW-1:0]      mm_b;
    logic               mm_run;
    logic [MW-1:0]      mm_result;

    modport master (
        input  req, req_a, req_b, mm_result,
        output grant, done, result, busy, mm_a, mm_b, mm_run
    );

    modport slave (
        output req, req_a, req_b, mm_result,
        input  grant, done, result, busy, mm_a, mm_b, mm_run
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic            o_valid,
    output logic [PW-1:0]   o_idx
);

    int            w_pos;
    logic [PW-1:0] w_cand;

    // Walk from the farthest offset down so the nearest hit is written last.
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        w_pos   = 0;
        w_cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            w_cand = PW'(w_pos);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/smm_scheduler.sv
// Shares one fixed-latency 4x4 multiplier between NREQ requesters, round-robin,
// returning each product with a one-cycle done strobe.
module smm_scheduler
    import kalman_pkg::*;
#(
    parameter int N       = SMM_N,
    parameter int Q       = 18,
    parameter int NREQ    = 4,
    parameter int LATENCY = SMM_LATENCY
) (
    input  logic            clk,
    input  logic            reset,
    smm_scheduler_if.master bus
);

    localparam int MW = 16 * N;
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(LATENCY);
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_GAP  = GAP;

    // Q only matters to the multiplier itself; here it is just sanity-checked.
    if (NREQ < 2 || NREQ > 8 || LATENCY < 2 || Q >= N) begin : g_bad_param
        $error("smm_scheduler: unsupported parameter set");
    end

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] r_grant;
    logic            r_done;
    logic            r_busy;
    logic            r_mm_run;
    logic [MW-1:0]   r_result;
    logic [MW-1:0]   r_mm_a;
    logic [MW-1:0]   r_mm_b;

    logic            w_pick_vld;
    logic [PW-1:0]   w_pick_idx;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_mm_run <= 1'b0;
            r_result <= '0;
            r_mm_a   <= '0;
            r_mm_b   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_grant  <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick_idx;
                        r_mm_a   <= bus.req_a[int'(w_pick_idx)*MW +: MW];
                        r_mm_b   <= bus.req_b[int'(w_pick_idx)*MW +: MW];
                        r_mm_run <= 1'b1;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_ptr    <= (w_pick_idx == PW'(NREQ - 1)) ? '0 : w_pick_idx + PW'(1);
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_result <= bus.mm_result;
                        r_done   <= 1'b1;
                        r_mm_run <= 1'b0;
                        r_state  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // Second low cycle of mm_run so the multiplier always clears.
                    r_done  <= 1'b0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant  = r_grant;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.busy   = r_busy;
    assign bus.mm_a   = r_mm_a;
    assign bus.mm_b   = r_mm_b;
    assign bus.mm_run = r_mm_run;

endmodule

// File: tb/tb_smm_scheduler.sv
// Bench for smm_scheduler: stand-in Q-format multiplier, timeline/arbitration scoreboard, directed and random traffic.
module tb_smm_scheduler;
    import kalman_pkg::*;

    localparam int L  = 18;
    localparam int NR = 4;
    localparam int NN = 32;
    localparam int QQ = 18;
    localparam int MW = MAT_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    smm_scheduler_if #(.N(NN), .NREQ(NR)) bus ();
    smm_scheduler #(.N(NN), .Q(QQ), .NREQ(NR), .LATENCY(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [NR-1:0]    req_drv = '0;
    logic [NR*MW-1:0] a_drv   = '0;
    logic [NR*MW-1:0] b_drv   = '0;
    assign bus.req   = req_drv;
    assign bus.req_a = a_drv;
    assign bus.req_b = b_drv;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference 4x4 Q-format product, row-major elements of NN bits.
    function automatic logic [MW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] c;
        longint s;
        c = '0;
        for (int r = 0; r < 4; r++) begin
            for (int col = 0; col < 4; col++) begin
                s = 0;
                for (int k = 0; k < 4; k++) begin
                    s += longint'($signed(a[(r*4+k)*NN +: NN])) * longint'($signed(b[(k*4+col)*NN +: NN]));
                end
                c[(r*4+col)*NN +: NN] = NN'(s >>> QQ);
            end
        end
        return c;
    endfunction

    function automatic logic [MW-1:0] rnd_mat();
        logic [MW-1:0] m;
        int e;
        for (int j = 0; j < 16; j++) begin
            e = int'($urandom_range(0, 1048575)) - 524288;
            m[j*NN +: NN] = e;
        end
        return m;
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr_first(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++) begin
            if (r[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    // Stand-in multiplier: the product is only correct on the cycle the scheduler should capture it.
    int run_cnt = 0;
    always @(posedge clk) run_cnt <= bus.mm_run ? run_cnt + 1 : 0;
    assign bus.mm_result = (run_cnt == L - 1) ? matmul(bus.mm_a, bus.mm_b) : ~matmul(bus.mm_a, bus.mm_b);

    logic [NR-1:0]    req_e   = '0;
    logic [NR*MW-1:0] a_e     = '0;
    logic [NR*MW-1:0] b_e     = '0;
    logic             reset_e = 1'b1;
    always @(posedge clk) begin
        req_e   <= req_drv;
        a_e     <= a_drv;
        b_e     <= b_drv;
        reset_e <= reset;
    end

    logic [MW-1:0] exp_q [NR][$];
    int            owner = -1;
    int            gcyc  = 0;
    int            cyc   = 0;
    int            mptr  = 0;
    logic [MW-1:0] fa, fb;
    logic [MW-1:0] last_res = '0;

    // Monitor: expected timeline per operation, round-robin rule at each idle sample.
    always @(negedge clk) begin
        int pick;
        int k;
        cyc = cyc + 1;
        if (reset_e) begin
            chk("rst_grant", bus.grant, '0);
            chk("rst_done", bus.done, '0);
            chk("rst_busy", bus.busy, '0);
            chk("rst_mm_run", bus.mm_run, '0);
            chk("rst_result", bus.result, '0);
            chk("rst_mm_a", bus.mm_a, '0);
            chk("rst_mm_b", bus.mm_b, '0);
            owner = -1;
            mptr = 0;
            last_res = '0;
        end else if (owner >= 0) begin
            k = cyc - gcyc;
            if (k < L) begin
                chk("run_grant", bus.grant, onehot(owner));
                chk("run_done", bus.done, '0);
                chk("run_mm_run", bus.mm_run, 1'b1);
                chk("run_busy", bus.busy, 1'b1);
                chk("run_mm_a_frozen", bus.mm_a, fa);
                chk("run_mm_b_frozen", bus.mm_b, fb);
                chk("run_result_held", bus.result, last_res);
            end else if (k == L) begin
                chk("done_grant", bus.grant, onehot(owner));
                chk("done_strobe", bus.done, 1'b1);
                chk("done_mm_run", bus.mm_run, '0);
                chk("done_busy", bus.busy, 1'b1);
                checks++;
                if (exp_q[owner].size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected owner=%0d actual=done required=no_done", owner);
                end else begin
                    last_res = exp_q[owner].pop_front();
                    chk("done_result", bus.result, last_res);
                end
            end else begin
                chk("gap_grant", bus.grant, '0);
                chk("gap_done", bus.done, '0);
                chk("gap_mm_run", bus.mm_run, '0);
                chk("gap_busy", bus.busy, '0);
                chk("gap_result_held", bus.result, last_res);
                owner = -1;
            end
        end else begin
            pick = rr_first(req_e, mptr);
            if (pick >= 0) begin
                fa = a_e[pick*MW +: MW];
                fb = b_e[pick*MW +: MW];
                chk("arb_grant", bus.grant, onehot(pick));
                chk("arb_mm_run", bus.mm_run, 1'b1);
                chk("arb_busy", bus.busy, 1'b1);
                chk("arb_done", bus.done, '0);
                chk("arb_mm_a", bus.mm_a, fa);
                chk("arb_mm_b", bus.mm_b, fb);
                owner = pick;
                gcyc = cyc;
                mptr = (pick + 1) % NR;
            end else begin
                chk("idle_grant", bus.grant, '0);
                chk("idle_done", bus.done, '0);
                chk("idle_busy", bus.busy, '0);
                chk("idle_mm_run", bus.mm_run, '0);
                chk("idle_result_held", bus.result, last_res);
            end
        end
    end

    task automatic issue(input int i, input logic [MW-1:0] a, input logic [MW-1:0] b);
        a_drv[i*MW +: MW] = a;
        b_drv[i*MW +: MW] = b;
        req_drv[i] = 1'b1;
        exp_q[i].push_back(matmul(a, b));
    endtask

    // Returns owner of the next done (or -1) and the number of cycles waited; clears that request.
    task automatic wait_done(output int o, output int w);
        o = -1;
        w = 0;
        for (int t = 0; t < 200 && o < 0; t++) begin
            @(negedge clk);
            w = t + 1;
            if (bus.done) begin
                for (int i = 0; i < NR; i++) if (bus.grant[i]) o = i;
            end
        end
        checks++;
        if (o < 0) begin
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_within_200");
            req_drv = '0;
        end else begin
            req_drv[o] = 1'b0;
        end
    endtask

    task automatic wait_grant(input int i);
        int seen;
        seen = 0;
        for (int t = 0; t < 200 && seen == 0; t++) begin
            @(negedge clk);
            if (bus.grant[i]) seen = 1;
        end
        chk("grant_seen", seen, 1);
    endtask

    initial begin
        int o, w, ndone;
        logic [MW-1:0] ia, db;
        int m;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // All four at once: order 0..3, LATENCY+2 apart.
        for (int i = 0; i < NR; i++) issue(i, rnd_mat(), rnd_mat());
        for (int j = 0; j < NR; j++) begin
            wait_done(o, w);
            chk("simul_order", o, j);
            if (j > 0) chk("simul_spacing", w, L + 2);
        end
        repeat (3) @(negedge clk);

        // Identity times diagonal returns the diagonal.
        ia = '0;
        db = '0;
        for (int d = 0; d < 4; d++) begin
            ia[(d*5)*NN +: NN] = 32'(1 << QQ);
            db[(d*5)*NN +: NN] = 32'((d + 1) << QQ);
        end
        issue(0, ia, db);
        wait_done(o, w);
        chk("single_owner", o, 0);
        chk("single_latency", w, L + 1);
        chk("single_result", bus.result, db);
        @(negedge clk);
        chk("single_grant_fall", bus.grant, '0);
        repeat (3) @(negedge clk);

        // Pointer wraps 3 -> 0, then re-requesting 0 must wait behind 2.
        issue(3, rnd_mat(), rnd_mat());
        wait_done(o, w);
        chk("fair_first", o, 3);
        repeat (3) @(negedge clk);
        issue(0, rnd_mat(), rnd_mat());
        issue(2, rnd_mat(), rnd_mat());
        wait_done(o, w);
        chk("fair_wrap_to_0", o, 0);
        @(negedge clk);
        issue(0, rnd_mat(), rnd_mat());
        wait_done(o, w);
        chk("fair_2_before_0", o, 2);
        wait_done(o, w);
        chk("fair_0_again", o, 0);
        repeat (3) @(negedge clk);

        // Request dropped while granted still completes.
        issue(1, rnd_mat(), rnd_mat());
        wait_grant(1);
        repeat (3) @(negedge clk);
        req_drv[1] = 1'b0;
        wait_done(o, w);
        chk("drop_owner", o, 1);
        repeat (3) @(negedge clk);

        // Operands scribbled during RUN must not reach the multiplier.
        issue(2, rnd_mat(), rnd_mat());
        wait_grant(2);
        @(negedge clk);
        a_drv[2*MW +: MW] = rnd_mat();
        b_drv[2*MW +: MW] = rnd_mat();
        wait_done(o, w);
        chk("opchg_owner", o, 2);
        repeat (3) @(negedge clk);

        // Reset at cnt=7 aborts with no done, then a fresh request works.
        issue(1, rnd_mat(), rnd_mat());
        wait_grant(1);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_drv[1] = 1'b0;
        exp_q[1].delete();
        ndone = 0;
        for (int t = 0; t < L + 4; t++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("reset_no_done", ndone, 0);
        issue(1, rnd_mat(), rnd_mat());
        wait_done(o, w);
        chk("reset_recover_owner", o, 1);
        chk("reset_recover_latency", w, L + 1);
        repeat (3) @(negedge clk);

        // Random traffic.
        for (int it = 0; it < 30; it++) begin
            if (req_drv == '0) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                m = int'($urandom_range(1, 15));
                for (int i = 0; i < NR; i++) if (m[i]) issue(i, rnd_mat(), rnd_mat());
            end else begin
                wait_done(o, w);
                @(negedge clk);
                for (int i = 0; i < NR; i++) begin
                    if (!req_drv[i] && $urandom_range(0, 2) == 0) issue(i, rnd_mat(), rnd_mat());
                end
            end
        end
        for (int g = 0; g < 8 && req_drv != '0; g++) wait_done(o, w);
        repeat (4) @(negedge clk);
        for (int i = 0; i < NR; i++) chk("scoreboard_empty", exp_q[i].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
